matmul_sequencer: RTL and testbench

Sequential controller for the 3x3 8-bit matrix-product datapath. It latches two packed operand matrices on a start pulse and schedules one multiply-accumulate per clock through a single shared multiplier. It writes each result element into a packed result register and signals completion with a one-cycle `done` pulse. It replaces the fully unrolled combinational product (27 multipliers) feeding the HEX display path and `Matrix_interface`.

---
 rtl/matmul_pkg.sv | 15 +
 rtl/matmul_mac.sv | 19 +
 rtl/matmul_sequencer.sv | 127 ++++++++++++
 tb/tb_matmul_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the 3x3 matrix-product sequencer.
package matmul_pkg;

  localparam int N        = 3;
  localparam int W        = 8;
  localparam int PACKED_W = N * N * W;
  localparam int IDX_W    = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/matmul_mac.sv
// Single shared multiply-accumulate: sum = (acc_in + a*b) mod 2^W.
module matmul_mac #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc_in,
  output logic [W-1:0] sum
);

  logic [2*W-1:0] prod;

  // Full-width product, then a wrapping W-bit sum; only the low W bits matter.
  always_comb begin
    prod = a * b;
    sum  = acc_in + prod[W-1:0];
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequential 3x3 matrix product: one MAC per clock through a shared multiplier.
module matmul_sequencer #(
  parameter int N = matmul_pkg::N,
  parameter int W = matmul_pkg::W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [N*N*W-1:0] niz1,
  input  logic [N*N*W-1:0] niz2,
  output logic [N*N*W-1:0] niz,
  output logic             busy,
  output logic             done,
  output logic             result_valid
);

  import matmul_pkg::*;

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state_q, state_d;
  logic [N*N*W-1:0] a_q, b_q, niz_q;
  logic [W-1:0]     acc_q;
  logic [IW-1:0]    i_q, j_q, l_q;
  logic             rv_q;
  logic [W-1:0]     a_el, b_el, sum;
  logic             accept, last_l, last_el;

  assign niz          = niz_q;
  assign result_valid = rv_q;
  assign last_l       = (l_q == LAST);
  assign last_el      = last_l && (j_q == LAST) && (i_q == LAST);

  // Select A[i][l] and B[l][j] from the latched operand copies.
  always_comb begin
    a_el = a_q[(int'(i_q) * N + int'(l_q)) * W +: W];
    b_el = b_q[(int'(l_q) * N + int'(j_q)) * W +: W];
  end

  matmul_mac #(.W(W)) u_mac (
    .a      (a_el),
    .b      (b_el),
    .acc_in (acc_q),
    .sum    (sum)
  );

  // Next-state and control outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_el) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A start in the DONE cycle is the earliest back-to-back restart.
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand latch, index counters, accumulator and result write-back.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // NOTE: operand and result registers are cleared too, so an aborted run leaves zeros.
      a_q   <= '0;
      b_q   <= '0;
      niz_q <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      l_q   <= '0;
      rv_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= niz1;
      b_q   <= niz2;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      l_q   <= '0;
      rv_q  <= 1'b0;
    end else if (state_q == RUN) begin
      if (!last_l) begin
        acc_q <= sum;
        l_q   <= l_q + IW'(1);
      end else begin
        niz_q[(int'(i_q) * N + int'(j_q)) * W +: W] <= sum;
        acc_q <= '0;
        l_q   <= '0;
        if (j_q == LAST) begin
          j_q <= '0;
          i_q <= (i_q == LAST) ? '0 : i_q + IW'(1);
        end else begin
          j_q <= j_q + IW'(1);
        end
        // Valid together with the DONE cycle, once the final element lands.
        if (last_el) rv_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed scoreboard bench for matmul_sequencer.
module tb_matmul_sequencer;

  import matmul_pkg::*;

  localparam int LAST_EDGE = N * N * N;  // done is high right after this edge past the start edge

  logic                CLOCK_50 = 1'b0;
  logic                reset;
  logic                start;
  logic [PACKED_W-1:0] niz1, niz2, niz;
  logic                busy, done, result_valid;

  int vectors     = 0;
  int miscompares = 0;
  logic [PACKED_W-1:0] exp_q[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  matmul_sequencer dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .start        (start),
    .niz1         (niz1),
    .niz2         (niz2),
    .niz          (niz),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid)
  );

  task automatic check(input string tag, input logic [PACKED_W-1:0] observed,
                       input logic [PACKED_W-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [PACKED_W-1:0] model(input logic [PACKED_W-1:0] a,
                                                input logic [PACKED_W-1:0] b);
    logic [PACKED_W-1:0] c;
    logic [W-1:0]        s;
    logic [2*W-1:0]      p;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int l = 0; l < N; l++) begin
          p = {{W{1'b0}}, a[(i*N+l)*W +: W]} * {{W{1'b0}}, b[(l*N+j)*W +: W]};
          s = s + p[W-1:0];
        end
        c[(i*N+j)*W +: W] = s;
      end
    end
    return c;
  endfunction

  function automatic logic [PACKED_W-1:0] mat_const(input int v);
    logic [PACKED_W-1:0] m;
    for (int k = 0; k < N*N; k++) m[k*W +: W] = W'(v);
    return m;
  endfunction

  function automatic logic [PACKED_W-1:0] mat_seq();
    logic [PACKED_W-1:0] m;
    for (int k = 0; k < N*N; k++) m[k*W +: W] = W'(k + 1);
    return m;
  endfunction

  function automatic logic [PACKED_W-1:0] mat_ident();
    logic [PACKED_W-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) m[(k*N+k)*W +: W] = W'(1);
    return m;
  endfunction

  // Drive one start edge (E0); push the expected product when the run should complete.
  task automatic start_run(input logic [PACKED_W-1:0] a, input logic [PACKED_W-1:0] b,
                           input bit push);
    niz1  = a;
    niz2  = b;
    start = 1'b1;
    if (push) exp_q.push_back(model(a, b));
    tick;
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed result %0h expected none queued", tag, niz);
    end else begin
      check(tag, niz, exp_q.pop_front());
    end
  endtask

  // Called just after E0; returns just after the edge that raised done.
  task automatic wait_done(input string tag);
    int edges, busy_cnt, rv_bad, overlap;
    edges    = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    rv_bad   = 0;
    overlap  = 0;
    while (done !== 1'b1 && edges < 100) begin
      tick;
      edges++;
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && result_valid !== 1'b0) rv_bad++;
      if (busy === 1'b1 && done === 1'b1) overlap++;
    end
    check({tag, "/latency"},   PACKED_W'(edges),        PACKED_W'(LAST_EDGE));
    check({tag, "/busy_cyc"},  PACKED_W'(busy_cnt),     PACKED_W'(LAST_EDGE));
    check({tag, "/rv_in_run"}, PACKED_W'(rv_bad),       PACKED_W'(0));
    check({tag, "/overlap"},   PACKED_W'(overlap),      PACKED_W'(0));
    check({tag, "/busy_done"}, PACKED_W'(busy),         PACKED_W'(0));
    check({tag, "/rv_done"},   PACKED_W'(result_valid), PACKED_W'(1));
    check_result({tag, "/result"});
  endtask

  initial begin
    logic [PACKED_W-1:0] ra, rb, rc, rd;
    int n_done;

    // Reset state.
    reset = 1'b1;
    start = 1'b1;
    niz1  = mat_const(1);
    niz2  = mat_const(1);
    repeat (2) tick;
    check("rst/busy", PACKED_W'(busy),         PACKED_W'(0));
    check("rst/done", PACKED_W'(done),         PACKED_W'(0));
    check("rst/rv",   PACKED_W'(result_valid), PACKED_W'(0));
    check("rst/niz",  niz,                     '0);
    start = 1'b0;
    reset = 1'b0;
    tick;
    check("idle/busy", PACKED_W'(busy), PACKED_W'(0));

    // Identity x 1..9.
    start_run(mat_ident(), mat_seq(), 1'b1);
    check("ident/busy_e0", PACKED_W'(busy), PACKED_W'(1));
    wait_done("ident");
    check("ident/c_direct", niz, mat_seq());
    tick;
    check("ident/done_e28", PACKED_W'(done),         PACKED_W'(0));
    check("ident/idle_e28", PACKED_W'(busy),         PACKED_W'(0));
    check("ident/rv_hold",  PACKED_W'(result_valid), PACKED_W'(1));

    // All-2 x all-1: every element 6; result_valid drops on the accepted start.
    start_run(mat_const(2), mat_const(1), 1'b1);
    check("all2/rv_clear", PACKED_W'(result_valid), PACKED_W'(0));
    wait_done("all2");
    check("all2/c_direct", niz, mat_const(6));
    tick;

    // Overflow: 3 * 100 = 300 wraps to 44.
    start_run(mat_const(10), mat_const(10), 1'b1);
    wait_done("ovf");
    check("ovf/c_direct", niz, mat_const(44));
    tick;

    // Start pulses at E5 and E27 are ignored.
    start_run(mat_seq(), mat_ident(), 1'b1);
    repeat (4) tick;
    niz1  = mat_const(5);
    niz2  = mat_const(7);
    start = 1'b1;
    tick;                              // E5
    start = 1'b0;
    repeat (21) tick;                  // up to E26
    start = 1'b1;
    tick;                              // E27
    start = 1'b0;
    check("ign/done_e27", PACKED_W'(done), PACKED_W'(1));
    check_result("ign/result");
    tick;                              // E28
    check("ign/busy_e28", PACKED_W'(busy), PACKED_W'(0));
    n_done = 0;
    repeat (35) begin
      tick;
      if (done === 1'b1) n_done++;
    end
    check("ign/extra_done", PACKED_W'(n_done), PACKED_W'(0));

    // Reset at E10 aborts the run.
    start_run(mat_const(3), mat_const(3), 1'b0);
    repeat (9) tick;
    reset = 1'b1;
    tick;                              // E10
    reset = 1'b0;
    check("abort/busy", PACKED_W'(busy),         PACKED_W'(0));
    check("abort/done", PACKED_W'(done),         PACKED_W'(0));
    check("abort/rv",   PACKED_W'(result_valid), PACKED_W'(0));
    check("abort/niz",  niz,                     '0);
    n_done = 0;
    repeat (30) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    check("abort/quiet", PACKED_W'(n_done), PACKED_W'(0));
    start_run(mat_ident(), mat_seq(), 1'b1);
    wait_done("post_rst");
    tick;

    // Operands altered after E0 have no effect; back-to-back restart at E28.
    ra = PACKED_W'({$urandom, $urandom, $urandom});
    rb = PACKED_W'({$urandom, $urandom, $urandom});
    rc = PACKED_W'({$urandom, $urandom, $urandom});
    rd = PACKED_W'({$urandom, $urandom, $urandom});
    start_run(ra, rb, 1'b1);
    niz1 = ~ra;
    niz2 = '0;
    wait_done("latched");
    start_run(rc, rd, 1'b1);           // E28
    check("b2b/busy_e28", PACKED_W'(busy), PACKED_W'(1));
    check("b2b/done_e28", PACKED_W'(done), PACKED_W'(0));
    niz1 = '0;
    wait_done("b2b");
    tick;
    check("b2b/done_low", PACKED_W'(done), PACKED_W'(0));
    check("sb/empty", PACKED_W'(exp_q.size()), PACKED_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
